// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: takes a byte on a one-cycle start strobe and sends
// one frame on the line: a start bit, then 8 data bits LSB first, then a stop bit.
// All outputs come straight from flops. The next-state logic computes the
// next value of each output, and the flops register it.
module uart_tx_8n1 #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned     CntW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      IdxMax = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   bit_end;

  assign bit_end = (cnt_q == CntMax);

  // Next-state logic. The outputs are the values for the next cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          shreg_d = tx_data;
          state_d = StStart;
          cnt_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StStart: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StData;
          tx_d    = shreg_q[0];
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IdxMax) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shreg_q[idx_d];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = StIdle;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers. On reset the line goes back to mark at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Bench for uart_tx_8n1. It drives three copies, with CLKS_PER_BIT of 4, 2 and 16.
// The bench pushes each expected frame into a scoreboard queue when it issues the
// start strobe. It pops the frame and checks it cycle by cycle while the DUT sends.
module tb_uart_tx_8n1;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit 0 = start bit, bits 1..8 = data LSB first, bit 9 = stop
  } vec_t;

  logic       clk;
  logic [2:0] rst_r;
  logic [2:0] start_r;
  logic [7:0] data_r [3];
  logic [2:0] tx_w;
  logic [2:0] busy_w;
  logic [2:0] done_w;

  logic [9:0] sb_q [$];
  vec_t       tbl [7];
  int         n_checks = 0;
  int         n_fail   = 0;

  uart_tx_8n1 #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .rst(rst_r[0]), .tx_start(start_r[0]), .tx_data(data_r[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );
  uart_tx_8n1 #(.CLKS_PER_BIT(2)) u_dut2 (
    .clk(clk), .rst(rst_r[1]), .tx_start(start_r[1]), .tx_data(data_r[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );
  uart_tx_8n1 #(.CLKS_PER_BIT(16)) u_dut16 (
    .clk(clk), .rst(rst_r[2]), .tx_start(start_r[2]), .tx_data(data_r[2]),
    .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nb(input int d);
    return (d == 0) ? 4 : (d == 1) ? 2 : 16;
  endfunction

  function automatic logic [2:0] obs(input int d);
    return {tx_w[d], busy_w[d], done_w[d]};
  endfunction

  task automatic chk(input string name, input int d, input int cyc,
                     input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: {tx,busy,done} got %b want %b",
               name, d, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1. The start strobe is accepted on the next edge.
  task automatic send(input int d, input int i);
    start_r[d] = 1'b1;
    data_r[d]  = tbl[i].data;
    sb_q.push_back(tbl[i].frame);
    tick();
    start_r[d] = 1'b0;
    data_r[d]  = ~tbl[i].data;  // later data changes must not reach the line
  endtask

  // Call just after the accepting edge. Checks the first ncyc cycles of the frame.
  task automatic check_partial(input int d, input int ncyc);
    int n;
    logic [9:0] f;
    n = nb(d);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard dut%0d: queue empty, want one frame", d);
      return;
    end
    f = sb_q.pop_front();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      chk("frame", d, c, obs(d), {f[c / n], 2'b10});
    end
  endtask

  // Checks a whole frame and the done cycle. With post set, also checks the idle
  // cycle that follows.
  task automatic check_frame(input int d, input bit post);
    int n;
    n = nb(d);
    check_partial(d, 10 * n);
    @(negedge clk);
    chk("done", d, 10 * n, obs(d), 3'b101);
    if (post) begin
      @(negedge clk);
      chk("post", d, 10 * n + 1, obs(d), 3'b100);
    end
  endtask

  task automatic idle_check(input int d, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      chk("idle", d, c, obs(d), 3'b100);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'hA5, 10'b1_1010_0101_0};
    tbl[1] = '{8'h3C, 10'b1_0011_1100_0};
    tbl[2] = '{8'h00, 10'b1_0000_0000_0};
    tbl[3] = '{8'hFF, 10'b1_1111_1111_0};
    tbl[4] = '{8'h55, 10'b1_0101_0101_0};
    tbl[5] = '{8'h81, 10'b1_1000_0001_0};
    tbl[6] = '{8'h96, 10'b1_1001_0110_0};

    rst_r   = 3'b111;
    start_r = 3'b000;
    for (int d = 0; d < 3; d++) data_r[d] = 8'h00;

    // Reset state, then 10 quiet cycles after release.
    #2;
    for (int d = 0; d < 3; d++) chk("reset", d, 0, obs(d), 3'b100);
    tick();
    tick();
    rst_r = 3'b000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) chk("reset_hold", d, c, obs(d), 3'b100);
    end

    // Send every byte in the table on the CLKS_PER_BIT=4 copy.
    for (int i = 0; i < 7; i++) begin
      tick();
      send(0, i);
      check_frame(0, 1'b1);
    end

    // A start strobe in mid-frame with new data is ignored and not queued.
    tick();
    send(0, 1);
    fork
      check_frame(0, 1'b1);
      begin
        repeat (10) tick();
        start_r[0] = 1'b1;
        data_r[0]  = 8'hFF;
        tick();
        start_r[0] = 1'b0;
      end
    join
    idle_check(0, 50);

    // Back-to-back frames with tx_start held high: one idle cycle between frames.
    tick();
    start_r[0] = 1'b1;
    data_r[0]  = tbl[2].data;
    sb_q.push_back(tbl[2].frame);
    tick();
    fork
      begin
        check_frame(0, 1'b0);
        check_frame(0, 1'b1);
      end
      begin
        repeat (20) tick();
        data_r[0] = tbl[3].data;
        sb_q.push_back(tbl[3].frame);
        repeat (30) tick();
        start_r[0] = 1'b0;
      end
    join
    idle_check(0, 10);

    // Reset during data bit 3 of 8'h55 abandons the frame and gives no done pulse.
    tick();
    send(0, 4);
    check_partial(0, 18);
    rst_r[0] = 1'b1;
    #1;
    chk("rst_mid", 0, 18, obs(0), 3'b100);
    tick();
    tick();
    chk("rst_hold", 0, 0, obs(0), 3'b100);
    rst_r[0] = 1'b0;
    idle_check(0, 10);
    tick();
    send(0, 5);
    check_frame(0, 1'b1);

    // Parameter sweep: CLKS_PER_BIT = 2 and 16 with 8'h96.
    for (int d = 1; d < 3; d++) begin
      tick();
      send(d, 6);
      check_frame(d, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
